// File: rtl/alu_ncl_result_receiver.sv
// Clocked receiver for the dual-rail (NCL) ALU result wavefront.
// Synchronizes the rails, filters for stable DATA/NULL completeness, decodes
// DATA to binary for a valid/ready consumer, and drives the stage ack_in.
module alu_ncl_result_receiver #(
    parameter int unsigned DATA_BITS   = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*DATA_BITS-1:0] soma,
    input  logic [1:0]             of,
    input  logic [1:0]             neg,
    input  logic [1:0]             zero,
    output logic                   ack,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [DATA_BITS-1:0]   res_data,
    output logic                   res_of,
    output logic                   res_neg,
    output logic                   res_zero,
    output logic                   err_illegal,
    output logic                   timeout
);

    localparam int unsigned NPAIR = DATA_BITS + 3;
    localparam int unsigned NRAIL = 2 * NPAIR;
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic {
        WAIT_DATA = 1'b0,
        WAIT_NULL = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [NRAIL-1:0]   rails;
    logic [NRAIL-1:0]   sync1;
    logic [NRAIL-1:0]   sync2;
    logic               smp_data;
    logic               smp_null;
    logic               smp_illegal;
    logic               data_q;
    logic               null_q;
    logic               stable_data;
    logic               stable_null;
    logic               blocked;
    logic               capture;
    logic [1:0]         pair;
    logic [DATA_BITS-1:0] dec_data;
    logic [CNT_W-1:0]   wd_cnt;

    // Flag pairs sit above the result pairs in one rail vector.
    assign rails = {zero, neg, of, soma};

    // Two-flop synchronizer on every rail; rails are monotonic within a phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= rails;
            sync2 <= sync1;
        end
    end

    // Classify the synchronized sample and decode the true rails to binary.
    always_comb begin
        smp_data    = 1'b1;
        smp_null    = 1'b1;
        smp_illegal = 1'b0;
        pair        = 2'b00;
        dec_data    = '0;
        for (int unsigned i = 0; i < NPAIR; i++) begin
            pair = sync2[2*i +: 2];
            if (pair == 2'b00) smp_data = 1'b0;
            if (pair != 2'b00) smp_null = 1'b0;
            if (pair == 2'b11) begin
                smp_illegal = 1'b1;
                smp_data    = 1'b0;
            end
        end
        for (int unsigned i = 0; i < DATA_BITS; i++) begin
            dec_data[i] = sync2[2*i+1];
        end
    end

    // Previous-sample completeness for the two-sample stability filter.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= 1'b0;
            null_q <= 1'b0;
        end else begin
            data_q <= smp_data;
            null_q <= smp_null;
        end
    end

    assign stable_data = smp_data && data_q;
    assign stable_null = smp_null && null_q;
    assign blocked     = res_valid && !res_ready;
    assign capture     = (state == WAIT_DATA) && stable_data && !smp_illegal && !blocked;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_DATA;
        else     state <= state_next;
    end

    // FSM next-state: DATA captured -> request NULL; stable NULL -> request DATA.
    always_comb begin
        state_next = state;
        case (state)
            WAIT_DATA: if (capture)     state_next = WAIT_NULL;
            WAIT_NULL: if (stable_null) state_next = WAIT_DATA;
            default:                    state_next = WAIT_DATA;
        endcase
    end

    // FSM output: ack comes straight from the single state flop, so it cannot glitch.
    always_comb begin
        ack = (state == WAIT_DATA);
    end

    // Output register: capture wins over a same-cycle consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_of    <= 1'b0;
            res_neg   <= 1'b0;
            res_zero  <= 1'b0;
        end else if (capture) begin
            res_valid <= 1'b1;
            res_data  <= dec_data;
            res_of    <= sync2[2*DATA_BITS+1];
            res_neg   <= sync2[2*DATA_BITS+3];
            res_zero  <= sync2[2*DATA_BITS+5];
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

    // Sticky illegal-encoding flag.
    always_ff @(posedge clk) begin
        if (rst)              err_illegal <= 1'b0;
        else if (smp_illegal) err_illegal <= 1'b1;
    end

    // Watchdog: a state change or backpressure restarts the count; a state change wins over a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (TIMEOUT_CYC == 0 || state_next != state || (state == WAIT_DATA && blocked)) begin
                wd_cnt <= '0;
            end else if (wd_cnt == CNT_LAST) begin
                wd_cnt  <= '0;
                timeout <= 1'b1;
            end else begin
                wd_cnt <= wd_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_ncl_result_receiver.sv
// Self-checking bench for alu_ncl_result_receiver: directed steps plus a
// random stress phase, with results tracked through an expected-value queue.
module tb_alu_ncl_result_receiver;

    localparam int DB = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [2*DB-1:0] soma;
    logic [1:0]    of;
    logic [1:0]    neg;
    logic [1:0]    zero;
    logic          ack;
    logic          res_valid;
    logic          res_ready;
    logic [DB-1:0] res_data;
    logic          res_of;
    logic          res_neg;
    logic          res_zero;
    logic          err_illegal;
    logic          timeout;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DB+2:0] sb[$];
    bit            rand_ready = 1'b0;

    alu_ncl_result_receiver #(
        .DATA_BITS   (DB),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .soma        (soma),
        .of          (of),
        .neg         (neg),
        .zero        (zero),
        .ack         (ack),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_of      (res_of),
        .res_neg     (res_neg),
        .res_zero    (res_zero),
        .err_illegal (err_illegal),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] enc(input logic b);
        return b ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [2*DB-1:0] enc_data(input logic [DB-1:0] d);
        logic [2*DB-1:0] r;
        r = '0;
        for (int i = 0; i < DB; i++) r[2*i +: 2] = enc(d[i]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: handshake at the coming edge is checked against the queue first.
    task automatic cycle();
        logic [DB+2:0] exp;
        if (rand_ready) res_ready = 1'($urandom_range(0, 1));
        if (rst === 1'b0 && res_valid === 1'b1 && res_ready === 1'b1) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check("sb_result", 32'({res_data, res_of, res_neg, res_zero}), 32'(exp));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic drive_null();
        soma = '0;
        of   = 2'b00;
        neg  = 2'b00;
        zero = 2'b00;
    endtask

    task automatic drive(input logic [DB-1:0] d, input logic o, input logic n, input logic z);
        soma = enc_data(d);
        of   = enc(o);
        neg  = enc(n);
        zero = enc(z);
        sb.push_back({d, o, n, z});
    endtask

    task automatic wait_ack(input logic val, input string tag);
        int i;
        i = 0;
        while (ack !== val && i < 300) begin
            cycle();
            i++;
        end
        check(tag, 32'(ack), 32'(val));
    endtask

    task automatic send(input logic [DB-1:0] d, input logic o, input logic n, input logic z);
        drive(d, o, n, z);
        wait_ack(1'b0, "send_ack_lo");
        drive_null();
        wait_ack(1'b1, "send_ack_hi");
    endtask

    initial begin
        logic [DB-1:0] da;
        logic [DB-1:0] dbv;

        rst       = 1'b1;
        res_ready = 1'b0;
        drive_null();
        @(negedge clk);
        do_reset();

        // Reset state
        check("rst_ack",       32'(ack),         32'd1);
        check("rst_valid",     32'(res_valid),   32'd0);
        check("rst_data",      32'(res_data),    32'd0);
        check("rst_of",        32'(res_of),      32'd0);
        check("rst_neg",       32'(res_neg),     32'd0);
        check("rst_zero",      32'(res_zero),    32'd0);
        check("rst_err",       32'(err_illegal), 32'd0);
        check("rst_timeout",   32'(timeout),     32'd0);

        // Basic capture with E4 latency
        res_ready = 1'b1;
        soma = 8'b10011010;
        of   = 2'b01;
        neg  = 2'b10;
        zero = 2'b01;
        sb.push_back({4'b1011, 1'b0, 1'b1, 1'b0});
        repeat (3) cycle();
        check("basic_e3_ack",   32'(ack),       32'd1);
        check("basic_e3_valid", 32'(res_valid), 32'd0);
        cycle();
        check("basic_valid", 32'(res_valid), 32'd1);
        check("basic_data",  32'(res_data),  32'hB);
        check("basic_of",    32'(res_of),    32'd0);
        check("basic_neg",   32'(res_neg),   32'd1);
        check("basic_zero",  32'(res_zero),  32'd0);
        check("basic_ack",   32'(ack),       32'd0);
        drive_null();
        repeat (3) cycle();
        check("null_e3_ack", 32'(ack), 32'd0);
        cycle();
        check("null_e4_ack", 32'(ack), 32'd1);
        check("null_valid",  32'(res_valid), 32'd0);

        // Partial arrival: pairs one per cycle, flags last
        da = 4'b0110;
        sb.push_back({da, 1'b1, 1'b0, 1'b0});
        for (int i = 0; i < DB; i++) begin
            soma[2*i +: 2] = enc(da[i]);
            cycle();
            check("partial_ack", 32'(ack), 32'd1);
        end
        of   = enc(1'b1);
        neg  = enc(1'b0);
        zero = enc(1'b0);
        repeat (3) cycle();
        check("partial_e3_ack",   32'(ack),       32'd1);
        check("partial_e3_valid", 32'(res_valid), 32'd0);
        cycle();
        check("partial_e4_ack",   32'(ack),       32'd0);
        check("partial_e4_valid", 32'(res_valid), 32'd1);
        drive_null();
        wait_ack(1'b1, "partial_null_ack");

        // Backpressure: second DATA waits until the first result is consumed
        res_ready = 1'b0;
        da  = 4'h5;
        dbv = 4'hA;
        send(da, 1'b1, 1'b0, 1'b1);
        drive(dbv, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) begin
            cycle();
            check("bp_ack",     32'(ack),      32'd1);
            check("bp_timeout", 32'(timeout),  32'd0);
            check("bp_hold",    32'(res_data), 32'(da));
        end
        res_ready = 1'b1;
        cycle();
        check("bp_valid", 32'(res_valid), 32'd1);
        check("bp_data",  32'(res_data),  32'(dbv));
        check("bp_ack_lo", 32'(ack),      32'd0);
        drive_null();
        wait_ack(1'b1, "bp_null_ack");
        cycle();

        // Illegal pair: sticky flag, no capture, cleared by reset
        do_reset();
        res_ready = 1'b1;
        soma = {enc(1'b1), enc(1'b0), enc(1'b1), 2'b11};
        of   = 2'b01;
        neg  = 2'b01;
        zero = 2'b10;
        repeat (2) cycle();
        check("ill_err_e2", 32'(err_illegal), 32'd0);
        cycle();
        check("ill_err_e3", 32'(err_illegal), 32'd1);
        repeat (8) cycle();
        check("ill_valid", 32'(res_valid),   32'd0);
        check("ill_ack",   32'(ack),         32'd1);
        check("ill_stick", 32'(err_illegal), 32'd1);
        drive_null();
        do_reset();
        check("ill_rst_err", 32'(err_illegal), 32'd0);

        // Watchdog: NULL held in WAIT_DATA, pulse every TO cycles
        for (int k = 1; k <= 40; k++) begin
            cycle();
            check("wd_pulse", 32'(timeout), 32'((k % TO) == 0));
        end

        // Stress with random data and random consumer readiness
        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            send(DB'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        rand_ready = 1'b0;
        res_ready  = 1'b1;
        repeat (5) cycle();
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("final_valid", 32'(res_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
